sobel_window_feeder: RTL and testbench
======================================

SOBEL_WINDOW_FEEDER -- requirements
Module: sobel_window_feeder

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, grayscale pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 8, pixels per row; legal range 3 to 1024.
REQ-003 SHALL have parameter IMG_HEIGHT, default 8, rows per frame; legal range 3 to 1024.
REQ-004 SHALL have port clk_i, input, 1, clock; all state changes on the rising edge.
REQ-005 SHALL have port nreset_i, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1, frame start request; sampled only in IDLE.
REQ-007 SHALL have port in_px_i, input, PIXEL_WIDTH, raster-order input pixel.
REQ-008 SHALL have port in_valid_i, input, 1, in_px_i is valid this cycle.
REQ-009 SHALL have port in_ready_o, output, 1, block accepts in_px_i this cycle.
REQ-010 SHALL have port out_px_o, output, PIXEL_WIDTH, window pixel to the Sobel stage.
REQ-011 SHALL have port px_rdy_o, output, 1, one-cycle strobe marking out_px_o valid.
REQ-012 SHALL have port start_sobel_o, output, 1, window-sequence-active level to the Sobel stage.
REQ-013 SHALL have port frame_done_o, output, 1, one-cycle pulse after the last window of the frame.

Function
REQ-014 SHALL accept a pixel only on a rising edge where in_valid_i and in_ready_o are both 1.
REQ-015 SHALL store pixels in a 3-row circular line store (3 x IMG_WIDTH entries); row r uses slot r mod 3.
REQ-016 SHALL track input column (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters; column wraps to 0 and row increments on the last accepted pixel of a row.
REQ-017 SHALL implement states IDLE, ACCEPT, EMIT9, EMIT3, ROW_GAP, DONE.
REQ-018 IDLE: in_ready_o=0; start_i=1 -> ACCEPT, counters cleared.
REQ-019 ACCEPT: in_ready_o=1; an accept at row>=2, column 2 -> EMIT9; an accept at row>=2, column>=3 -> EMIT3; otherwise remain in ACCEPT.
REQ-020 EMIT9: in_ready_o=0; emits 9 pixels on 9 consecutive cycles, column-major for columns c-2, c-1, c, each column in top, middle, bottom order (rows r-2, r-1, r).
REQ-021 EMIT3: in_ready_o=0; emits 3 pixels on 3 consecutive cycles for column c, in top, middle, bottom order.
REQ-022 SHALL assert the first emitted pixel on the cycle after the accepting edge, with px_rdy_o=1 on every emission cycle and 0 otherwise.
REQ-023 After an emission, the next state SHALL be ROW_GAP if c = IMG_WIDTH-1 and r < IMG_HEIGHT-1, DONE if c = IMG_WIDTH-1 and r = IMG_HEIGHT-1, and ACCEPT otherwise.
REQ-024 ROW_GAP: lasts exactly 1 cycle with start_sobel_o=0 and in_ready_o=0, then -> ACCEPT.
REQ-025 start_sobel_o SHALL be 1 from entry into EMIT9 until that row's ROW_GAP or DONE, and 0 otherwise.
REQ-026 DONE: lasts 1 cycle with frame_done_o=1, then -> IDLE.
REQ-027 Per frame, the block SHALL emit exactly (IMG_HEIGHT-2) x (9 + 3 x (IMG_WIDTH-3)) pixels.
REQ-028 out_px_o SHALL hold its last value when px_rdy_o=0.
REQ-029 in_valid_i while in_ready_o=0 SHALL have no effect; the pixel is not consumed.
REQ-030 start_i outside IDLE SHALL be ignored; a start_i held high continuously SHALL begin a new frame on the cycle after DONE returns the block to IDLE.

Reset
REQ-031 On nreset_i low, the block SHALL immediately enter IDLE, clear all counters, and set in_ready_o=0, px_rdy_o=0, start_sobel_o=0, frame_done_o=0 and out_px_o=0.
REQ-032 Line-store contents SHALL NOT require a reset; no stale pixel SHALL be emitted, because emission requires 2 freshly filled rows.
REQ-033 Reset asserted mid-frame SHALL abort the frame, and the next frame SHALL start only on a new start_i.

Verification
REQ-034 Defaults; start_i pulse; 64 pixels with value = row*8+col and in_valid_i held 1 -> 144 px_rdy_o strobes; first 9 outputs 0, 8, 16, 1, 9, 17, 2, 10, 18; next 3 outputs 3, 11, 19.
REQ-035 Same frame -> start_sobel_o falls for exactly 1 cycle after each of rows 2-6 and never during emission; a single frame_done_o pulse follows the 144th strobe.
REQ-036 in_valid_i toggled pseudo-randomly at 50 percent -> identical output sequence to REQ-034; no pixel lost or duplicated.
REQ-037 nreset_i pulsed low after the 30th output strobe -> all outputs 0 at once; a following start_i and full frame reproduce the REQ-034 sequence exactly.
REQ-038 IMG_WIDTH=3, IMG_HEIGHT=3; pixels 1 to 9 -> exactly 9 strobes (1, 4, 7, 2, 5, 8, 3, 6, 9), no EMIT3 state, then frame_done_o.
REQ-039 start_i held 1 through DONE -> IDLE lasts 1 cycle and in_ready_o returns to 1 on the following cycle.

Source files
------------

// File: rtl/sobel_window_feeder_if.sv
// Pixel stream and window handshake between raster source, window feeder and Sobel stage.
interface sobel_window_feeder_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   start_i;
  logic [PIXEL_WIDTH-1:0] in_px_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [PIXEL_WIDTH-1:0] out_px_o;
  logic                   px_rdy_o;
  logic                   start_sobel_o;
  logic                   frame_done_o;

  modport master (
    output start_i, in_px_i, in_valid_i,
    input  in_ready_o, out_px_o, px_rdy_o, start_sobel_o, frame_done_o
  );

  modport slave (
    input  start_i, in_px_i, in_valid_i,
    output in_ready_o, out_px_o, px_rdy_o, start_sobel_o, frame_done_o
  );
endinterface

// File: rtl/sobel_window_feeder.sv
// Buffers a raster frame in a 3-row line store and replays 3x3 windows (first column
// of a row as a full 9-pixel window, later columns as 3-pixel column updates).
module sobel_window_feeder #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  sobel_window_feeder_if.slave  bus
);
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int DEPTH = 3 * IMG_WIDTH;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, ACCEPT, EMIT9, EMIT3, ROW_GAP, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [1:0]             slot;
  logic [1:0]             top_slot;
  logic [CW-1:0]          em_col;
  logic [1:0]             em_row;
  logic [3:0]             em_left;
  logic [CW-1:0]          win_col;
  logic                   win_last;
  logic                   in_ready;
  logic                   px_rdy;
  logic                   start_sobel;
  logic                   frame_done;
  logic [PIXEL_WIDTH-1:0] out_px;
  logic [PIXEL_WIDTH-1:0] line_mem [DEPTH];
  logic                   accept;

  function automatic logic [1:0] slot_add(input logic [1:0] s, input logic [1:0] d);
    logic [2:0] t;
    t = {1'b0, s} + {1'b0, d};
    return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [1:0] s, input logic [CW-1:0] c);
    return AW'(s) * AW'(IMG_WIDTH) + AW'(c);
  endfunction

  assign accept = bus.in_valid_i & in_ready;

  // Line store holds no reset: a window is only replayed once two fresh rows are in.
  always_ff @(posedge clk_i) begin
    if (accept) line_mem[addr_of(slot, col)] <= bus.in_px_i;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      slot        <= '0;
      top_slot    <= '0;
      em_col      <= '0;
      em_row      <= '0;
      em_left     <= '0;
      win_col     <= '0;
      win_last    <= 1'b0;
      in_ready    <= 1'b0;
      px_rdy      <= 1'b0;
      start_sobel <= 1'b0;
      frame_done  <= 1'b0;
      out_px      <= '0;
    end else begin
      px_rdy     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
            col      <= '0;
            row      <= '0;
            slot     <= '0;
          end
        end
        ACCEPT: begin
          if (accept) begin
            if (col == CW'(IMG_WIDTH - 1)) begin
              col  <= '0;
              row  <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
              slot <= slot_add(slot, 2'd1);
            end else begin
              col <= col + 1'b1;
            end
            // The first window pixel (oldest row) is already stored, so it leaves next cycle.
            if (row >= RW'(2) && col >= CW'(2)) begin
              in_ready    <= 1'b0;
              start_sobel <= 1'b1;
              px_rdy      <= 1'b1;
              win_col     <= col;
              win_last    <= (row == RW'(IMG_HEIGHT - 1));
              top_slot    <= slot_add(slot, 2'd1);
              em_row      <= 2'd1;
              if (col == CW'(2)) begin
                state   <= EMIT9;
                em_col  <= '0;
                em_left <= 4'd8;
                out_px  <= line_mem[addr_of(slot_add(slot, 2'd1), '0)];
              end else begin
                state   <= EMIT3;
                em_col  <= col;
                em_left <= 4'd2;
                out_px  <= line_mem[addr_of(slot_add(slot, 2'd1), col)];
              end
            end
          end
        end
        EMIT9, EMIT3: begin
          if (em_left != 4'd0) begin
            px_rdy  <= 1'b1;
            out_px  <= line_mem[addr_of(slot_add(top_slot, em_row), em_col)];
            em_left <= em_left - 4'd1;
            if (em_row == 2'd2) begin
              em_row <= 2'd0;
              em_col <= em_col + 1'b1;
            end else begin
              em_row <= em_row + 2'd1;
            end
          end else if (win_col == CW'(IMG_WIDTH - 1)) begin
            start_sobel <= 1'b0;
            if (win_last) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state <= ROW_GAP;
            end
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
          end
        end
        ROW_GAP: begin
          state    <= ACCEPT;
          in_ready <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.out_px_o      = out_px;
  assign bus.px_rdy_o      = px_rdy;
  assign bus.start_sobel_o = start_sobel;
  assign bus.frame_done_o  = frame_done;
endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder: 8x8 default frame and a 3x3 minimum frame.
module tb_sobel_window_feeder;
  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  sobel_window_feeder_if #(.PIXEL_WIDTH(8)) bus8();
  sobel_window_feeder_if #(.PIXEL_WIDTH(8)) bus3();

  sobel_window_feeder #(.PIXEL_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
    .clk_i(clk), .nreset_i(nreset), .bus(bus8)
  );
  sobel_window_feeder #(.PIXEL_WIDTH(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
    .clk_i(clk), .nreset_i(nreset), .bus(bus3)
  );

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp8 [$];
  logic [7:0] obs8 [$];
  logic [7:0] obs3 [$];
  logic [7:0] exp3 [9] = '{8'd1, 8'd4, 8'd7, 8'd2, 8'd5, 8'd8, 8'd3, 8'd6, 8'd9};
  int done8 = 0, done3 = 0, fall8 = 0, viol8 = 0;
  int size_at_done8 = 0, size_at_done3 = 0;
  logic prev_ss = 1'b0;
  bit abort8 = 1'b0;

  always @(negedge clk) begin
    if (bus8.px_rdy_o) obs8.push_back(bus8.out_px_o);
    if (bus8.frame_done_o) begin
      done8 <= done8 + 1;
      size_at_done8 <= obs8.size();
    end
    if (prev_ss && !bus8.start_sobel_o) fall8 <= fall8 + 1;
    if (bus8.px_rdy_o && !bus8.start_sobel_o) viol8 <= viol8 + 1;
    prev_ss <= bus8.start_sobel_o;
    if (bus3.px_rdy_o) obs3.push_back(bus3.out_px_o);
    if (bus3.frame_done_o) begin
      done3 <= done3 + 1;
      size_at_done3 <= obs3.size();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start8();
    @(negedge clk); bus8.start_i = 1'b1;
    @(negedge clk); bus8.start_i = 1'b0;
  endtask

  task automatic send8(input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit v;
    while (idx < 64 && cyc < 3000 && !abort8) begin
      @(negedge clk); cyc++;
      if (abort8) break;
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus8.in_valid_i = v;
      bus8.in_px_i    = 8'(idx);
      if (v && bus8.in_ready_o) idx++;
    end
    @(negedge clk); bus8.in_valid_i = 1'b0;
    if (!abort8) begin
      compared++;
      if (idx != 64) begin
        mismatched++;
        $display("FAIL send8_accept: accepted %0d pixels, required 64", idx);
      end
    end
  endtask

  task automatic wait_done8(input int d0);
    int cyc = 0;
    while (done8 == d0 && cyc < 500) begin @(negedge clk); cyc++; end
    compared++;
    if (done8 == d0) begin
      mismatched++;
      $display("FAIL wait_done8: frame_done_o count %0d, required %0d", done8, d0 + 1);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    bus8.start_i = 1'b0; bus8.in_valid_i = 1'b0; bus8.in_px_i = 8'd0;
    bus3.start_i = 1'b0; bus3.in_valid_i = 1'b0; bus3.in_px_i = 8'd0;
    repeat (2) @(negedge clk);
    compared += 6;
    if (bus8.in_ready_o !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %b want 0", bus8.in_ready_o); end
    if (bus8.px_rdy_o !== 1'b0) begin mismatched++; $display("FAIL rst_px_rdy: got %b want 0", bus8.px_rdy_o); end
    if (bus8.start_sobel_o !== 1'b0) begin mismatched++; $display("FAIL rst_start_sobel: got %b want 0", bus8.start_sobel_o); end
    if (bus8.frame_done_o !== 1'b0) begin mismatched++; $display("FAIL rst_frame_done: got %b want 0", bus8.frame_done_o); end
    if (bus8.out_px_o !== 8'd0) begin mismatched++; $display("FAIL rst_out_px: got %0d want 0", bus8.out_px_o); end
    if (bus3.in_ready_o !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready3: got %b want 0", bus3.in_ready_o); end
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (bus8.in_ready_o !== 1'b0) begin mismatched++; $display("FAIL idle_in_ready: got %b want 0", bus8.in_ready_o); end
  endtask

  task automatic test_frame(input bit rnd);
    int d0 = done8;
    int f0 = fall8;
    int v0 = viol8;
    obs8.delete();
    pulse_start8();
    send8(rnd);
    wait_done8(d0);
    repeat (4) @(negedge clk);
    compared++;
    if (obs8.size() != 144) begin mismatched++; $display("FAIL frame_count: got %0d strobes want 144", obs8.size()); end
    for (int i = 0; i < 144 && i < obs8.size(); i++) begin
      compared++;
      if (obs8[i] !== exp8[i]) begin
        mismatched++;
        $display("FAIL frame_px[%0d]: got %0d want %0d", i, obs8[i], exp8[i]);
      end
    end
    compared += 3;
    if (done8 - d0 != 1) begin mismatched++; $display("FAIL frame_done_pulses: got %0d want 1", done8 - d0); end
    if (size_at_done8 != 144) begin mismatched++; $display("FAIL done_after_last: strobes at done %0d want 144", size_at_done8); end
    if (viol8 != v0) begin mismatched++; $display("FAIL start_sobel_low_in_emit: got %0d cycles want 0", viol8 - v0); end
    if (!rnd) begin
      compared++;
      if (fall8 - f0 != 6) begin mismatched++; $display("FAIL start_sobel_falls: got %0d want 6", fall8 - f0); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0 = done8;
    obs8.delete();
    abort8 = 1'b0;
    pulse_start8();
    fork
      send8(1'b0);
      begin
        int cyc = 0;
        while (obs8.size() < 30 && cyc < 2000) begin @(negedge clk); cyc++; end
        compared++;
        if (obs8.size() < 30) begin mismatched++; $display("FAIL mid_reach30: got %0d strobes want 30", obs8.size()); end
        abort8 = 1'b1;
        nreset = 1'b0;
        #1;
        compared += 5;
        if (bus8.in_ready_o !== 1'b0) begin mismatched++; $display("FAIL mid_in_ready: got %b want 0", bus8.in_ready_o); end
        if (bus8.px_rdy_o !== 1'b0) begin mismatched++; $display("FAIL mid_px_rdy: got %b want 0", bus8.px_rdy_o); end
        if (bus8.start_sobel_o !== 1'b0) begin mismatched++; $display("FAIL mid_start_sobel: got %b want 0", bus8.start_sobel_o); end
        if (bus8.frame_done_o !== 1'b0) begin mismatched++; $display("FAIL mid_frame_done: got %b want 0", bus8.frame_done_o); end
        if (bus8.out_px_o !== 8'd0) begin mismatched++; $display("FAIL mid_out_px: got %0d want 0", bus8.out_px_o); end
        @(negedge clk); nreset = 1'b1;
      end
    join
    abort8 = 1'b0;
    bus8.in_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    compared += 2;
    if (bus8.in_ready_o !== 1'b0) begin mismatched++; $display("FAIL abort_stays_idle: in_ready %b want 0", bus8.in_ready_o); end
    if (done8 != d0) begin mismatched++; $display("FAIL abort_no_done: got %0d pulses want 0", done8 - d0); end
    bus8.in_valid_i = 1'b0;
    test_frame(1'b0);
  endtask

  task automatic test_start_held();
    int cyc = 0;
    @(negedge clk); bus8.start_i = 1'b1;
    send8(1'b0);
    while (bus8.frame_done_o !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
    compared++;
    if (bus8.frame_done_o !== 1'b1) begin mismatched++; $display("FAIL held_done: frame_done_o %b want 1", bus8.frame_done_o); end
    @(negedge clk);
    compared++;
    if (bus8.in_ready_o !== 1'b0) begin mismatched++; $display("FAIL held_idle_cycle: in_ready %b want 0", bus8.in_ready_o); end
    @(negedge clk);
    compared++;
    if (bus8.in_ready_o !== 1'b1) begin mismatched++; $display("FAIL held_restart: in_ready %b want 1", bus8.in_ready_o); end
    bus8.start_i = 1'b0;
    nreset = 1'b0;
    @(negedge clk); nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_min_frame();
    int d0 = done3;
    int idx = 0;
    int cyc = 0;
    obs3.delete();
    @(negedge clk); bus3.start_i = 1'b1;
    @(negedge clk); bus3.start_i = 1'b0;
    while (idx < 9 && cyc < 500) begin
      @(negedge clk); cyc++;
      bus3.in_valid_i = 1'b1;
      bus3.in_px_i    = 8'(idx + 1);
      if (bus3.in_ready_o) idx++;
    end
    @(negedge clk); bus3.in_valid_i = 1'b0;
    cyc = 0;
    while (done3 == d0 && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    compared += 3;
    if (obs3.size() != 9) begin mismatched++; $display("FAIL min_count: got %0d strobes want 9", obs3.size()); end
    if (done3 - d0 != 1) begin mismatched++; $display("FAIL min_done: got %0d pulses want 1", done3 - d0); end
    if (size_at_done3 != 9) begin mismatched++; $display("FAIL min_done_after_last: strobes at done %0d want 9", size_at_done3); end
    for (int i = 0; i < 9 && i < obs3.size(); i++) begin
      compared++;
      if (obs3[i] !== exp3[i]) begin mismatched++; $display("FAIL min_px[%0d]: got %0d want %0d", i, obs3[i], exp3[i]); end
    end
  endtask

  initial begin
    // Expected window order: row r, column c window; pixel value = row*8+col.
    for (int r = 2; r < 8; r++) begin
      for (int c = 2; c < 8; c++) begin
        if (c == 2) begin
          for (int cc = 0; cc < 3; cc++)
            for (int rr = r - 2; rr <= r; rr++) exp8.push_back(8'(rr * 8 + cc));
        end else begin
          for (int rr = r - 2; rr <= r; rr++) exp8.push_back(8'(rr * 8 + c));
        end
      end
    end
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_reset_mid_frame();
    test_start_held();
    test_min_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
